// File: rtl/hex_out_pkg.sv
// Shared constants and types for the seven-segment I/O-port responder.
// Register offsets are relative to the port window base.
package hex_out_pkg;

  localparam logic [2:0] OFS_DIG0  = 3'd0;
  localparam logic [2:0] OFS_DIG1  = 3'd1;
  localparam logic [2:0] OFS_DIG2  = 3'd2;
  localparam logic [2:0] OFS_DIG3  = 3'd3;
  localparam logic [2:0] OFS_BLANK = 3'd4;
  localparam logic [2:0] OFS_BLINK = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/hex_seg_decoder.sv
// Nibble to active-low seven-segment glyph (bit 6 = g, bit 0 = a).
// Letters b and d are lowercase so they stay distinct from 8 and 0.
module hex_seg_decoder (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    unique case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_out_port.sv
// 8080 port-mapped responder driving eight seven-segment digits.
// Every port cycle completes with a single-cycle ready pulse.
module hex_out_port
  import hex_out_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'h10,
  parameter int         BLINK_W   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  input  logic       io_wr,
  input  logic       io_rd,
  output logic [7:0] io_rdata,
  output logic       io_ready,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [6:0] hex6,
  output logic [6:0] hex7
);

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_dig [4];
  logic [7:0]         r_blank;
  logic [7:0]         r_blink;
  logic [7:0]         r_rdata;
  logic [BLINK_W-1:0] r_cnt;

  logic [7:0] w_ofs;
  logic       w_hit;
  logic       w_wr_en;
  logic       w_rd_en;
  logic [7:0] w_rd_val;
  logic [7:0] w_dark;
  logic [6:0] w_seg [8];
  logic [6:0] w_hex [8];

  // Offset wraps for addresses below the base; the >= guard rejects them.
  assign w_ofs = io_addr - BASE_PORT;
  assign w_hit = (io_addr >= BASE_PORT) && (w_ofs < 8'd6);

  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (io_wr) begin
          w_wr_en = 1'b1;
          w_next  = RESP;
        end else if (io_rd) begin
          w_rd_en = 1'b1;
          w_next  = RESP;
        end
      end
      RESP: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rd_val = 8'hFF;
    if (w_hit) begin
      unique case (w_ofs[2:0])
        OFS_DIG0:  w_rd_val = r_dig[0];
        OFS_DIG1:  w_rd_val = r_dig[1];
        OFS_DIG2:  w_rd_val = r_dig[2];
        OFS_DIG3:  w_rd_val = r_dig[3];
        OFS_BLANK: w_rd_val = r_blank;
        OFS_BLINK: w_rd_val = r_blink;
        default:   w_rd_val = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dig   <= '{default: 8'h00};
      r_blank <= 8'hFF;
      r_blink <= 8'h00;
      r_rdata <= 8'h00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_cnt + 1'b1;
      if (w_rd_en) r_rdata <= w_rd_val;
      if (w_wr_en && w_hit) begin
        unique case (w_ofs[2:0])
          OFS_DIG0:  r_dig[0] <= io_wdata;
          OFS_DIG1:  r_dig[1] <= io_wdata;
          OFS_DIG2:  r_dig[2] <= io_wdata;
          OFS_DIG3:  r_dig[3] <= io_wdata;
          OFS_BLANK: r_blank  <= io_wdata;
          OFS_BLINK: r_blink  <= io_wdata;
          default: ;
        endcase
      end
    end
  end

  assign io_ready = (r_state == RESP);
  assign io_rdata = r_rdata;
  assign w_dark   = r_blank | (r_blink & {8{r_cnt[BLINK_W-1]}});

  for (genvar i = 0; i < 8; i++) begin : g_dig
    hex_seg_decoder u_dec (
      .i_nib (r_dig[i/2][4*(i%2) +: 4]),
      .o_seg (w_seg[i])
    );
    assign w_hex[i] = w_dark[i] ? SEG_BLANK : w_seg[i];
  end

  assign hex0 = w_hex[0];
  assign hex1 = w_hex[1];
  assign hex2 = w_hex[2];
  assign hex3 = w_hex[3];
  assign hex4 = w_hex[4];
  assign hex5 = w_hex[5];
  assign hex6 = w_hex[6];
  assign hex7 = w_hex[7];

endmodule

// File: tb/tb_hex_out_port.sv
// Directed bench for hex_out_port with a short blink counter.
// Inputs change just after posedge; outputs are sampled at negedge.
module tb_hex_out_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] io_addr = 8'h00;
  logic [7:0] io_wdata = 8'h00;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [7:0] io_rdata;
  logic       io_ready;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [6:0] hex4, hex5, hex6, hex7;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] m_cnt = 4'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_cnt <= 4'd0;
    else       m_cnt <= m_cnt + 4'd1;
  end

  hex_out_port #(
    .BASE_PORT (8'h10),
    .BLINK_W   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_rdata (io_rdata),
    .io_ready (io_ready),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .hex6     (hex6),
    .hex7     (hex7)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_dark(input string tag);
    check({tag, " hex0"}, 32'(hex0), 32'h7F);
    check({tag, " hex1"}, 32'(hex1), 32'h7F);
    check({tag, " hex2"}, 32'(hex2), 32'h7F);
    check({tag, " hex3"}, 32'(hex3), 32'h7F);
    check({tag, " hex4"}, 32'(hex4), 32'h7F);
    check({tag, " hex5"}, 32'(hex5), 32'h7F);
    check({tag, " hex6"}, 32'(hex6), 32'h7F);
    check({tag, " hex7"}, 32'(hex7), 32'h7F);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    @(posedge clk);
    #1 io_wr = 1'b0;
    @(negedge clk);
    check("wr ready", 32'(io_ready), 32'h1);
    @(negedge clk);
    check("wr ready drop", 32'(io_ready), 32'h0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    io_addr = a;
    io_rd   = 1'b1;
    @(posedge clk);
    #1 io_rd = 1'b0;
    @(negedge clk);
    check("rd ready", 32'(io_ready), 32'h1);
    check("rd data", 32'(io_rdata), 32'(exp));
    @(negedge clk);
    check("rd ready drop", 32'(io_ready), 32'h0);
    check("rd data hold", 32'(io_rdata), 32'(exp));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check_all_dark("reset");
    check("reset ready", 32'(io_ready), 32'h0);
    check("reset rdata", 32'(io_rdata), 32'h0);

    do_write(8'h14, 8'h00);
    do_write(8'h10, 8'hA5);
    check("hex0 5", 32'(hex0), 32'h12);
    check("hex1 A", 32'(hex1), 32'h08);
    check("hex2 0", 32'(hex2), 32'h40);
    check("hex7 0", 32'(hex7), 32'h40);

    do_write(8'h12, 8'h3C);
    check("hex4 C", 32'(hex4), 32'h46);
    check("hex5 3", 32'(hex5), 32'h30);
    do_read(8'h12, 8'h3C);
    do_read(8'h20, 8'hFF);
    do_read(8'h0F, 8'hFF);
    do_read(8'h16, 8'hFF);
    do_read(8'h10, 8'hA5);
    check("hex0 keep", 32'(hex0), 32'h12);

    // write wins when both strobes are high
    @(negedge clk);
    io_addr  = 8'h11;
    io_wdata = 8'h77;
    io_wr    = 1'b1;
    io_rd    = 1'b1;
    @(posedge clk);
    #1 begin io_wr = 1'b0; io_rd = 1'b0; end
    @(negedge clk);
    check("both ready", 32'(io_ready), 32'h1);
    check("both rdata", 32'(io_rdata), 32'hA5);
    @(negedge clk);
    check("both one pulse", 32'(io_ready), 32'h0);
    @(negedge clk);
    check("both idle", 32'(io_ready), 32'h0);
    check("hex2 7", 32'(hex2), 32'h78);
    check("hex3 7", 32'(hex3), 32'h78);
    do_read(8'h11, 8'h77);

    do_write(8'h15, 8'h01);
    do_read(8'h15, 8'h01);
    do_read(8'h14, 8'h00);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("blink hex0", 32'(hex0), m_cnt[3] ? 32'h7F : 32'h12);
      check("blink hex1", 32'(hex1), 32'h08);
    end

    // reset lands in the RESP cycle of a write
    @(negedge clk);
    io_addr  = 8'h10;
    io_wdata = 8'h99;
    io_wr    = 1'b1;
    @(posedge clk);
    #1 begin io_wr = 1'b0; reset = 1'b1; end
    @(negedge clk);
    check("rst resp ready", 32'(io_ready), 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst ready", 32'(io_ready), 32'h0);
    check("rst rdata", 32'(io_rdata), 32'h0);
    check_all_dark("rst");
    do_read(8'h10, 8'h00);
    do_read(8'h14, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
